// File: rtl/core_seq_v2.sv
// core_seq_v2: multi-cycle fetch/decode/execute core with an 8-entry register
// file, Z/S/C/O flags, a small ALU and a request/response data-memory port.
// Started by interrupt_start from SLEEP; HALT returns to SLEEP and pulses
// interrupt_finish.
// Optional feature macro: CORE_SEQ_V2_MUL_EN. When defined, opcode 6 is a
// multiply. When undefined, opcode 6 behaves as a NOP and no multiplier exists.
module core_seq_v2 #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CORE_IDX_W = 2,
  parameter logic [63:0] START_ADDR = 64'd0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  interrupt_start,
  output logic                  interrupt_finish,
  output logic                  busy,
  input  logic [CORE_IDX_W-1:0] core_index,
  output logic [WIDTH-1:0]      instr_addr,
  input  logic [15:0]           instruction,
  output logic                  request,
  input  logic                  response,
  output logic                  wren,
  output logic [WIDTH-1:0]      address,
  output logic [WIDTH-1:0]      writedata,
  input  logic [WIDTH-1:0]      readdata
);

  typedef enum logic [2:0] {
    ST_SLEEP, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM_WAIT
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL, OP_CMP,
    OP_LDI, OP_SHLI, OP_MOV, OP_LD, OP_ST, OP_JMP, OP_CID, OP_HALT
  } op_e;

  localparam logic [WIDTH-1:0] START_IP = START_ADDR[WIDTH-1:0];
  localparam logic [WIDTH-1:0] IP_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ip_q, ip_d;
  op_e              op_q, op_d;
  logic [2:0]       rd_q, rd_d, rs_q, rs_d;
  logic [8:0]       imm_q, imm_d;
  logic             z_q, z_d, s_q, s_d, c_q, c_d, o_q, o_d;
  logic             request_q, request_d, wren_q, wren_d, finish_q, finish_d;
  logic [WIDTH-1:0] address_q, address_d, writedata_q, writedata_d;

  logic [WIDTH-1:0] rf_q [8];
  logic             rf_we;
  logic [2:0]       rf_waddr;
  logic [WIDTH-1:0] rf_wdata;

  logic [WIDTH-1:0] rd_val, rs_val;
  logic [WIDTH:0]   sum, diff, shl_full;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_o, alu_upd, cond_true;

  // The overflow flag has no consumer yet (no overflow jump condition).
  logic unused_o_flag;
  assign unused_o_flag = o_q;

  assign rd_val   = rf_q[rd_q];
  assign rs_val   = rf_q[rs_q];
  assign sum      = {1'b0, rd_val} + {1'b0, rs_val};
  assign diff     = {1'b0, rd_val} - {1'b0, rs_val};
  // Extra top bit catches the last bit shifted out; a shift of 0 leaves it 0.
  assign shl_full = {1'b0, rd_val} << imm_q[3:0];

`ifdef CORE_SEQ_V2_MUL_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = {{WIDTH{1'b0}}, rd_val} * {{WIDTH{1'b0}}, rs_val};
`endif

  assign busy             = (state_q != ST_SLEEP);
  assign instr_addr       = ip_q;
  assign interrupt_finish = finish_q;
  assign request          = request_q;
  assign wren             = wren_q;
  assign address          = address_q;
  assign writedata        = writedata_q;

  // ALU result and flag sources for the register-register ops.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    alu_upd = 1'b0;
    case (op_q)
      OP_ADD: begin
        {alu_c, alu_res} = sum;
        alu_o   = (rd_val[WIDTH-1] == rs_val[WIDTH-1]) && (sum[WIDTH-1] != rd_val[WIDTH-1]);
        alu_upd = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        {alu_c, alu_res} = diff;
        alu_o   = (rd_val[WIDTH-1] != rs_val[WIDTH-1]) && (diff[WIDTH-1] != rd_val[WIDTH-1]);
        alu_upd = 1'b1;
      end
      OP_AND: begin
        alu_res = rd_val & rs_val;
        alu_upd = 1'b1;
      end
      OP_OR: begin
        alu_res = rd_val | rs_val;
        alu_upd = 1'b1;
      end
      OP_XOR: begin
        alu_res = rd_val ^ rs_val;
        alu_upd = 1'b1;
      end
`ifdef CORE_SEQ_V2_MUL_EN
      OP_MUL: begin
        alu_res = prod[WIDTH-1:0];
        alu_c   = |prod[2*WIDTH-1:WIDTH];
        alu_o   = |prod[2*WIDTH-1:WIDTH];
        alu_upd = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Jump condition selected by the rs field.
  always_comb begin
    case (rs_q)
      3'd0:    cond_true = 1'b1;
      3'd1:    cond_true = z_q;
      3'd2:    cond_true = !z_q;
      3'd3:    cond_true = c_q;
      3'd4:    cond_true = !c_q;
      3'd5:    cond_true = s_q;
      3'd6:    cond_true = !s_q;
      default: cond_true = 1'b0;
    endcase
  end

  // Sequencer next-state, register-file write and memory-port control.
  always_comb begin
    state_d     = state_q;
    ip_d        = ip_q;
    op_d        = op_q;
    rd_d        = rd_q;
    rs_d        = rs_q;
    imm_d       = imm_q;
    z_d         = z_q;
    s_d         = s_q;
    c_d         = c_q;
    o_d         = o_q;
    request_d   = request_q;
    wren_d      = wren_q;
    address_d   = address_q;
    writedata_d = writedata_q;
    finish_d    = 1'b0;
    rf_we       = 1'b0;
    rf_waddr    = rd_q;
    rf_wdata    = '0;

    case (state_q)
      ST_SLEEP: begin
        if (interrupt_start) begin
          ip_d    = START_IP;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        op_d    = op_e'(instruction[15:12]);
        rd_d    = instruction[11:9];
        rs_d    = instruction[8:6];
        imm_d   = instruction[8:0];
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        ip_d    = ip_q + IP_ONE;
        state_d = ST_FETCH;
        case (op_q)
          OP_LDI: begin
            rf_we    = 1'b1;
            rf_wdata = {{(WIDTH-9){imm_q[8]}}, imm_q};
          end
          OP_SHLI: begin
            rf_we    = 1'b1;
            rf_wdata = shl_full[WIDTH-1:0];
            z_d      = (shl_full[WIDTH-1:0] == '0);
            s_d      = shl_full[WIDTH-1];
            c_d      = shl_full[WIDTH];
          end
          OP_MOV: begin
            rf_we    = 1'b1;
            rf_wdata = rs_val;
          end
          OP_CID: begin
            rf_we    = 1'b1;
            rf_wdata = {{(WIDTH-CORE_IDX_W){1'b0}}, core_index};
          end
          OP_LD, OP_ST: begin
            // ip advances only once the memory transfer completes.
            ip_d      = ip_q;
            state_d   = ST_MEM_WAIT;
            request_d = 1'b1;
            address_d = rs_val;
            wren_d    = (op_q == OP_ST);
            if (op_q == OP_ST) writedata_d = rd_val;
          end
          OP_JMP: begin
            if (cond_true) ip_d = rd_val;
          end
          OP_HALT: begin
            ip_d     = ip_q;
            finish_d = 1'b1;
            state_d  = ST_SLEEP;
          end
          default: begin
            if (alu_upd) begin
              rf_we    = (op_q != OP_CMP);
              rf_wdata = alu_res;
              z_d      = (alu_res == '0);
              s_d      = alu_res[WIDTH-1];
              c_d      = alu_c;
              o_d      = alu_o;
            end
          end
        endcase
      end
      ST_MEM_WAIT: begin
        if (response) begin
          request_d = 1'b0;
          ip_d      = ip_q + IP_ONE;
          state_d   = ST_FETCH;
          if (!wren_q) begin
            rf_we    = 1'b1;
            rf_wdata = readdata;
          end
        end
      end
      default: state_d = ST_SLEEP;
    endcase
  end

  // Control, flag and memory-port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SLEEP;
      ip_q        <= START_IP;
      op_q        <= OP_NOP;
      rd_q        <= '0;
      rs_q        <= '0;
      imm_q       <= '0;
      z_q         <= 1'b0;
      s_q         <= 1'b0;
      c_q         <= 1'b0;
      o_q         <= 1'b0;
      request_q   <= 1'b0;
      wren_q      <= 1'b0;
      address_q   <= '0;
      writedata_q <= '0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ip_q        <= ip_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      rs_q        <= rs_d;
      imm_q       <= imm_d;
      z_q         <= z_d;
      s_q         <= s_d;
      c_q         <= c_d;
      o_q         <= o_d;
      request_q   <= request_d;
      wren_q      <= wren_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      finish_q    <= finish_d;
    end
  end

  // Register file: at most one write per instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule
